// File: rtl/keccak_absorb_pad.sv
// -----------------------------------------------------------------------------
// keccak_absorb_pad
//
// Front end of the Keccak-p[1600] permutation. It absorbs a little-endian
// stream of 64-bit message words into the 1600-bit state, using original-Keccak
// padding (0x01 ... 0x80) at a rate of RATE_LANES lanes. It starts the core once
// per block and captures the permuted state. After the final block it offers
// that state downstream with a valid/ready handshake.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready       word handshake; o_ready is high only while absorbing
//   i_data                message word, byte k = bits [8k+7:8k]
//   i_last, i_nbytes      final-word marker and its valid byte count (0..8, >8 -> 8)
//   o_start               one-cycle start pulse to the permutation core
//   o_v_num_rounds        round count for the core (NUM_ROUNDS)
//   o_state               state presented to the core, lane i = bits [64i+63:64i]
//   i_done, i_state       core completion pulse and permuted state
//   o_hash_valid          final state available
//   i_hash_ready          downstream accepts the final state
//   o_hash_state          final state (same register as o_state)
// -----------------------------------------------------------------------------
module keccak_absorb_pad #(
  parameter int RATE_LANES = 17,
  parameter int NUM_ROUNDS = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [63:0]   i_data,
  input  logic          i_last,
  input  logic [3:0]    i_nbytes,
  output logic          o_start,
  output logic [4:0]    o_v_num_rounds,
  output logic [1599:0] o_state,
  input  logic          i_done,
  input  logic [1599:0] i_state,
  output logic          o_hash_valid,
  input  logic          i_hash_ready,
  output logic [1599:0] o_hash_state
);

  typedef enum logic [2:0] {ABSORB, START, WAIT, PADBLK, OUTPUT} state_t;

  localparam logic [4:0] LAST_LANE   = 5'(RATE_LANES - 1);
  // Top bit of the last rate lane: the 0x80 end-of-padding marker lives here.
  localparam int         PAD_END_BIT = 64 * RATE_LANES - 1;

  function automatic logic [3:0] clamp_nbytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

  // Zero every byte at or above position n so trailing garbage in the final
  // word never reaches the state.
  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [3:0] n);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < n) m[8*k +: 8] = d[8*k +: 8];
    end
    return m;
  endfunction

  state_t        state_q, state_d;
  logic [4:0]    cnt_q;
  logic          pend_pad_q;
  logic          final_q;

  logic          accept;
  logic [3:0]    nb;
  logic          full_last;
  logic [10:0]   lane_base;
  logic [1599:0] absorb_vec;

  assign o_v_num_rounds = 5'(NUM_ROUNDS);
  assign o_hash_state   = o_state;

  // Absorb vector: data word plus any padding bits, XORed into the state in
  // one step on an accepted word.
  always_comb begin
    accept     = i_valid && (state_q == ABSORB);
    nb         = clamp_nbytes(i_nbytes);
    // A full final word in the last rate lane leaves no room for padding;
    // the padding then goes into a separate block via PADBLK.
    full_last  = i_last && (nb == 4'd8) && (cnt_q == LAST_LANE);
    lane_base  = {cnt_q, 6'd0};
    absorb_vec = '0;
    absorb_vec[lane_base +: 64] = i_last ? mask_bytes(i_data, nb) : i_data;
    if (i_last && !full_last) begin
      if (nb != 4'd8) absorb_vec[lane_base + {5'd0, nb[2:0], 3'd0}] = 1'b1;
      else            absorb_vec[lane_base + 11'd64]                = 1'b1;
      // XOR rather than set: with 135 message bytes both markers land in the
      // same byte and combine to 0x81.
      absorb_vec[PAD_END_BIT] = absorb_vec[PAD_END_BIT] ^ 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    o_ready      = 1'b0;
    o_start      = 1'b0;
    o_hash_valid = 1'b0;
    case (state_q)
      ABSORB: begin
        o_ready = 1'b1;
        if (accept && (i_last || (cnt_q == LAST_LANE))) state_d = START;
      end
      START: begin
        o_start = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (i_done) begin
          if (final_q)         state_d = OUTPUT;
          else if (pend_pad_q) state_d = PADBLK;
          else                 state_d = ABSORB;
        end
      end
      PADBLK: state_d = START;
      OUTPUT: begin
        o_hash_valid = 1'b1;
        if (i_hash_ready) state_d = ABSORB;
      end
      default: state_d = ABSORB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ABSORB;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      pend_pad_q <= 1'b0;
      final_q    <= 1'b0;
      o_state    <= '0;
    end else begin
      case (state_q)
        ABSORB: begin
          if (accept) begin
            o_state <= o_state ^ absorb_vec;
            if (i_last) begin
              cnt_q <= '0;
              if (full_last) begin
                pend_pad_q <= 1'b1;
                final_q    <= 1'b0;
              end else begin
                final_q    <= 1'b1;
              end
            end else if (cnt_q == LAST_LANE) begin
              cnt_q   <= '0;
              final_q <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + 5'd1;
            end
          end
        end
        WAIT: begin
          if (i_done) o_state <= i_state;
        end
        PADBLK: begin
          o_state[0]           <= ~o_state[0];
          o_state[PAD_END_BIT] <= ~o_state[PAD_END_BIT];
          pend_pad_q           <= 1'b0;
          final_q              <= 1'b1;
        end
        OUTPUT: begin
          if (i_hash_ready) begin
            o_state <= '0;
            cnt_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_absorb_pad.sv
module tb_keccak_absorb_pad;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid = 1'b0;
  logic          ready;
  logic [63:0]   data = '0;
  logic          last = 1'b0;
  logic [3:0]    nbytes = '0;
  logic          start;
  logic [4:0]    nr;
  logic [1599:0] st;
  logic          done = 1'b0;
  logic [1599:0] core_state = '0;
  logic          hash_valid;
  logic          hash_ready = 1'b0;
  logic [1599:0] hst;

  keccak_absorb_pad dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_data         (data),
    .i_last         (last),
    .i_nbytes       (nbytes),
    .o_start        (start),
    .o_v_num_rounds (nr),
    .o_state        (st),
    .i_done         (done),
    .i_state        (core_state),
    .o_hash_valid   (hash_valid),
    .i_hash_ready   (hash_ready),
    .o_hash_state   (hst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  always @(posedge clk) if (start === 1'b1) n_starts <= n_starts + 1;

  logic [1599:0] exp_q[$];
  logic [1599:0] resp_q[$];
  logic [1599:0] hash_q[$];
  logic [7:0]    msg  [0:279];
  logic [7:0]    padb [0:279];
  logic [1599:0] blk0_st;
  bit            grab_first;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wide(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
    int ln;
    ln = 0;
    for (int i = 24; i >= 0; i--) if (obs[64*i +: 64] !== exp[64*i +: 64]) ln = i;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s lane%0d observed=%h expected=%h", tag, ln, obs[64*ln +: 64], exp[64*ln +: 64]);
    end
  endtask

  function automatic logic [1599:0] mk_resp(input logic [1599:0] s, input int blk);
    return {s[1598:0], s[1599]} ^ {25{64'h0123_4567_89AB_CDEF ^ 64'(blk)}};
  endfunction

  // Byte-level reference: pad the message to whole 136-byte blocks, then
  // absorb block by block, chaining through the stand-in core response.
  task automatic model_msg(input int len, input int id);
    int nblk;
    logic [1599:0] s, r;
    nblk = len / 136 + 1;
    for (int b = 0; b < 280; b++) padb[b] = 8'h00;
    for (int b = 0; b < len; b++) begin
      msg[b]  = 8'(b * 7 + 3 + id * 13);
      padb[b] = msg[b];
    end
    padb[len]           = padb[len] ^ 8'h01;
    padb[nblk*136 - 1]  = padb[nblk*136 - 1] ^ 8'h80;
    s = '0;
    for (int blk = 0; blk < nblk; blk++) begin
      for (int j = 0; j < 136; j++) s[8*j +: 8] = s[8*j +: 8] ^ padb[blk*136 + j];
      exp_q.push_back(s);
      r = mk_resp(s, blk);
      resp_q.push_back(r);
      s = r;
    end
    hash_q.push_back(s);
  endtask

  task automatic drive_word(input logic [63:0] d, input logic l, input logic [3:0] n);
    for (int i = 0; i < 50 && ready !== 1'b1; i++) @(negedge clk);
    chk1("wait_ready", ready, 1'b1);
    valid = 1'b1; data = d; last = l; nbytes = n;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; last = 1'b0; data = '0; nbytes = '0;
  endtask

  task automatic serve(input bit now, input bit fin);
    logic [1599:0] e, r;
    if (!now) for (int i = 0; i < 50 && start !== 1'b1; i++) @(negedge clk);
    chk1(now ? "start_latency" : "start_seen", start, 1'b1);
    e = exp_q.pop_front();
    r = resp_q.pop_front();
    if (grab_first) begin
      blk0_st    = st;
      grab_first = 1'b0;
    end
    chk_wide("block_state", st, e);
    @(negedge clk);
    chk1("start_one_cycle", start, 1'b0);
    chk_wide("state_stable_wait", st, e);
    repeat (2) @(negedge clk);
    done = 1'b1; core_state = r;
    @(negedge clk);
    done = 1'b0; core_state = ~r;
    chk1("hash_valid_after_done", hash_valid, fin);
  endtask

  task automatic send_msg(input int len, input int id, input int bp, input bit nb_over);
    int nw, nblk, served, lastn;
    logic [63:0] wd;
    logic [3:0]  nbv;
    logic [1599:0] h;
    model_msg(len, id);
    nblk       = len / 136 + 1;
    nw         = (len == 0) ? 1 : (len + 7) / 8;
    lastn      = len - 8 * (nw - 1);
    served     = 0;
    grab_first = 1'b1;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 8; k++) wd[8*k +: 8] = (8*w + k < len) ? msg[8*w + k] : 8'hFF;
      nbv = (w == nw - 1) ? 4'(lastn) : 4'd8;
      if (nb_over && nbv == 4'd8) nbv = 4'hF;
      drive_word(wd, (w == nw - 1), nbv);
      if ((w == nw - 1) || (w % 17 == 16)) begin
        serve(1'b1, served == nblk - 1);
        served++;
      end
    end
    while (served < nblk) begin
      serve(1'b0, served == nblk - 1);
      served++;
    end
    for (int i = 0; i < 50 && hash_valid !== 1'b1; i++) @(negedge clk);
    chk1("hash_valid", hash_valid, 1'b1);
    h = hash_q.pop_front();
    chk_wide("hash_state", hst, h);
    chk1("ready_low_in_output", ready, 1'b0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk_wide("hash_hold", hst, h);
      chk1("hash_valid_hold", hash_valid, 1'b1);
      chk1("ready_hold_low", ready, 1'b0);
    end
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    chk1("ready_after_handshake", ready, 1'b1);
    chk1("hash_valid_cleared", hash_valid, 1'b0);
    chk_wide("state_cleared", st, '0);
  endtask

  initial begin
    int s0;
    logic [1599:0] ev;

    // Reset state
    repeat (2) @(negedge clk);
    chk_wide("reset_state", st, '0);
    chk1("reset_hash_valid", hash_valid, 1'b0);
    chk1("reset_start", start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("reset_ready", ready, 1'b1);
    chk64("num_rounds", 64'(nr), 64'd24);

    // 76-byte blob: pad in lane 9 byte 4, end marker in lane 16
    s0 = n_starts;
    send_msg(76, 1, 0, 1'b0);
    chk64("b76_lane9_upper", 64'(blk0_st[64*9+32 +: 32]), 64'h0000_0000_0000_0001);
    chk64("b76_lane16", blk0_st[64*16 +: 64], 64'h8000_0000_0000_0000);
    chk64("b76_starts", 64'(n_starts - s0), 64'd1);

    // Empty message with all-ones data
    send_msg(0, 2, 0, 1'b0);
    ev = '0; ev[0] = 1'b1; ev[1087] = 1'b1;
    chk_wide("empty_block", blk0_st, ev);

    // 136 bytes: padding needs an extra block
    s0 = n_starts;
    send_msg(136, 3, 0, 1'b0);
    chk64("b136_starts", 64'(n_starts - s0), 64'd2);

    // 135 bytes: both pad markers in byte 135
    send_msg(135, 4, 0, 1'b0);
    chk64("b135_byte135", 64'(blk0_st[1080 +: 8]), 64'h81);

    // Back-pressure on the output
    send_msg(20, 5, 10, 1'b0);

    // i_nbytes above 8 behaves as 8
    send_msg(16, 7, 0, 1'b1);

    // Reset while waiting on the core
    drive_word(64'h1122_3344_5566_7788, 1'b1, 4'd3);
    chk1("rst_test_start", start, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_wide("rst_async_state", st, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done = 1'b1; core_state = {50{$urandom}};
    @(negedge clk);
    done = 1'b0;
    chk1("rst_ready", ready, 1'b1);
    chk1("rst_hash_valid", hash_valid, 1'b0);
    chk1("rst_start", start, 1'b0);
    chk_wide("rst_state", st, '0);
    repeat (3) @(negedge clk);
    done = 1'b1; core_state = {50{$urandom}};
    @(negedge clk);
    done = 1'b0;
    chk1("spurious_done_ready", ready, 1'b1);
    chk1("spurious_done_hash_valid", hash_valid, 1'b0);
    chk_wide("spurious_done_state", st, '0);

    // Normal operation resumes after reset
    send_msg(9, 6, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
